// File: rtl/la_arb_pkg.sv
// Shared arbiter-library definitions: FSM encoding, index width and one-hot helpers.
// No logic of its own; used by la_rrpick and la_rrarb4.
package la_arb_pkg;

  localparam logic IDLE = 1'b0;
  localparam logic BUSY = 1'b1;

  // Index width for N requesters; never below 1 so ports stay legal.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Callers slice the low N bits.
  function automatic logic [31:0] onehot32(input int idx);
    return 32'd1 << idx;
  endfunction

endpackage

// File: rtl/la_rrpick.sv
// Combinational rotate-priority picker: first set req bit after ptr, wrapping.
// Zero latency; no backpressure (pure function of req and ptr).
module la_rrpick
  import la_arb_pkg::*;
#(
  parameter int    N    = 4,
  parameter string PROP = "DEFAULT",
  localparam int   IW   = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] pick,
  output logic          any
);

  logic [2*N-1:0] dbl;

  assign dbl = {req, req};

  // Window (ptr, ptr+N] of the doubled vector; lowest set bit wins.
  always_comb begin
    pick = '0;
    any  = 1'b0;
    for (int j = 2*N-1; j >= 0; j--) begin
      if (dbl[j] && (j > int'(ptr)) && (j <= int'(ptr) + N)) begin
        pick = IW'(j % N);
        any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/la_rrarb4.sv
// Registered round-robin arbiter with transfer locking; one-hot gnt drives downstream mux selects.
// Latency: grant 1 cycle after request; one idle bubble after every release. Holds grant while ready is low.
module la_rrarb4
  import la_arb_pkg::*;
#(
  parameter int    N    = 4,
  parameter string PROP = "DEFAULT",
  localparam int   IW   = idx_w(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  req,
  input  logic          last,
  input  logic          ready,
  output logic [N-1:0]  gnt,
  output logic          gnt_valid,
  output logic [IW-1:0] gnt_id
);

  logic          state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] pick;
  logic          any;
  logic          release_now;
  logic [31:0]   pick_oh;

  la_rrpick #(
    .N    (N),
    .PROP (PROP)
  ) u_pick (
    .req  (req),
    .ptr  (ptr),
    .pick (pick),
    .any  (any)
  );

  assign pick_oh = onehot32(int'(pick));

  // A beat counts only with ready; an abort by the owner releases regardless of last.
  assign release_now = (state == BUSY) && ((ready && last) || !req[gnt_id]);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= IW'(N-1);
      gnt       <= '0;
      gnt_valid <= 1'b0;
      gnt_id    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any) begin
            gnt       <= pick_oh[N-1:0];
            gnt_id    <= pick;
            gnt_valid <= 1'b1;
            state     <= BUSY;
          end
        end
        default: begin
          if (release_now) begin
            ptr       <= gnt_id;
            gnt       <= '0;
            gnt_id    <= '0;
            gnt_valid <= 1'b0;
            state     <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_la_rrarb4.sv
// Directed checks of la_rrarb4: reset, rotation, locking, abort, reset mid-transfer, last without ready.
module tb_la_rrarb4;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic       last;
  logic       ready;
  logic [3:0] gnt;
  logic       gnt_valid;
  logic [1:0] gnt_id;

  int total = 0;
  int bad   = 0;

  la_rrarb4 #(.N(4), .PROP("DEFAULT")) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .last      (last),
    .ready     (ready),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected id/valid are derived from the expected one-hot grant.
  task automatic chk(input string tag, input logic [3:0] eg);
    logic [1:0] eid;
    logic       ev;
    ev  = (eg != 4'b0000);
    eid = 2'd0;
    for (int i = 0; i < 4; i++) if (eg[i]) eid = 2'(i);
    total++;
    assert (gnt === eg && gnt_valid === ev && gnt_id === eid) else begin
      bad++;
      $error("FAIL %s: gnt=%b valid=%b id=%0d expected gnt=%b valid=%b id=%0d",
             tag, gnt, gnt_valid, gnt_id, eg, ev, eid);
    end
  endtask

  logic [3:0] seq [9];
  logic       rdy_seq [7];

  initial begin
    seq = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
            4'b0000, 4'b1000, 4'b0000, 4'b0001};
    rdy_seq = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

    reset = 1'b1; req = 4'b0000; last = 1'b0; ready = 1'b0;
    tick(); tick();
    chk("reset", 4'b0000);
    reset = 1'b0;
    tick();
    chk("idle_noreq", 4'b0000);

    // Basic grant, release, rotation to id 3.
    req = 4'b1010;
    tick(); chk("t1_grant1", 4'b0010);
    ready = 1'b1; last = 1'b1;
    tick(); chk("t1_release", 4'b0000);
    ready = 1'b0; last = 1'b0;
    tick(); chk("t1_grant3", 4'b1000);
    ready = 1'b1; last = 1'b1;
    tick(); chk("t1_release3", 4'b0000);
    req = 4'b0000;
    tick(); chk("t1_idle", 4'b0000);

    // All requesting, single-beat transfers: fair rotation with bubbles.
    req = 4'b1111;
    for (int i = 0; i < 9; i++) begin
      tick(); chk($sformatf("t2_rot%0d", i), seq[i]);
    end

    // Abort of id 0 with only req[2] left, then locked 5-beat transfer on id 2.
    req = 4'b0100; ready = 1'b0; last = 1'b0;
    tick(); chk("t3_abort0", 4'b0000);
    tick(); chk("t3_grant2", 4'b0100);
    req = 4'b1111;
    for (int i = 0; i < 7; i++) begin
      ready = rdy_seq[i];
      last  = (i == 6);
      tick();
      chk($sformatf("t3_beat%0d", i), (i == 6) ? 4'b0000 : 4'b0100);
    end
    ready = 1'b0; last = 1'b0;
    tick(); chk("t3_next3", 4'b1000);

    // Grant id 0, then owner abort with last=0; ptr=0 gives id 1 next.
    ready = 1'b1; last = 1'b1;
    tick(); chk("t4_rel3", 4'b0000);
    ready = 1'b0; last = 1'b0;
    tick(); chk("t4_grant0", 4'b0001);
    req = 4'b1110;
    tick(); chk("t4_abort", 4'b0000);
    req = 4'b0011;
    tick(); chk("t4_grant1", 4'b0010);

    // Reset while busy on id 3.
    req = 4'b1000;
    tick(); chk("t5_abort1", 4'b0000);
    tick(); chk("t5_grant3", 4'b1000);
    reset = 1'b1;
    tick(); chk("t5_reset", 4'b0000);
    reset = 1'b0; req = 4'b1001;
    tick(); chk("t5_after_reset", 4'b0001);

    // last without ready never releases.
    last = 1'b1; ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(); chk($sformatf("t6_hold%0d", i), 4'b0001);
    end
    ready = 1'b1;
    tick(); chk("t6_release", 4'b0000);

    // Released requester alone is re-granted; simultaneous abort + last releases once.
    req = 4'b0001; ready = 1'b0; last = 1'b0;
    tick(); chk("t7_regrant0", 4'b0001);
    req = 4'b0000; ready = 1'b1; last = 1'b1;
    tick(); chk("t7_dual_release", 4'b0000);
    req = 4'b0110; ready = 1'b0; last = 1'b0;
    tick(); chk("t7_after_dual", 4'b0010);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
